// File: rtl/bcd_down_counter.sv
// Two-digit synchronous BCD down counter with parallel load, enable,
// cascadable borrow and a parameter-selected underflow policy (wrap/reload/stop).
module bcd_down_counter #(
  parameter int WRAP_MODE = 0
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [3:0] d_ones,
  input  logic [3:0] d_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc,
  output logic       borrow,
  output logic       done
);

  logic [3:0] rld_ones;
  logic [3:0] rld_tens;

  // Out-of-range load digits clamp to 9 so the count is always legal BCD.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign tc     = (tens == 4'd0) && (ones == 4'd0);
  assign borrow = (WRAP_MODE == 2) ? 1'b0 : (tc & EN & ~LOAD);

  always_ff @(posedge clk) begin
    if (RST) begin
      ones     <= 4'd0;
      tens     <= 4'd0;
      rld_ones <= 4'd0;
      rld_tens <= 4'd0;
      done     <= 1'b0;
    end else if (LOAD) begin
      ones     <= sat_digit(d_ones);
      tens     <= sat_digit(d_tens);
      rld_ones <= sat_digit(d_ones);
      rld_tens <= sat_digit(d_tens);
      done     <= 1'b0;
    end else if (EN) begin
      if (tc) begin
        if (WRAP_MODE == 0) begin
          ones <= 4'd9;
          tens <= 4'd9;
          done <= 1'b1;
        end else if (WRAP_MODE == 1) begin
          ones <= rld_ones;
          tens <= rld_tens;
          done <= 1'b1;
        end else begin
          done <= 1'b0;
        end
      end else begin
        if (ones != 4'd0) begin
          ones <= ones - 4'd1;
        end else begin
          ones <= 4'd9;
          tens <= tens - 4'd1;
        end
        // Stop mode flags arrival at 00 rather than the (suppressed) underflow.
        done <= (WRAP_MODE == 2) && (tens == 4'd0) && (ones == 4'd1);
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: one instance per underflow policy,
// all driven by the same stimulus, each scenario checking the relevant one.
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       RST, EN, LOAD;
  logic [3:0] d_ones, d_tens;

  logic [3:0] ones0, tens0, ones1, tens1, ones2, tens2;
  logic       tc0, tc1, tc2, borrow0, borrow1, borrow2, done0, done1, done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.WRAP_MODE(0)) u0 (
    .clk(clk), .RST(RST), .EN(EN), .LOAD(LOAD), .d_ones(d_ones), .d_tens(d_tens),
    .ones(ones0), .tens(tens0), .tc(tc0), .borrow(borrow0), .done(done0));
  bcd_down_counter #(.WRAP_MODE(1)) u1 (
    .clk(clk), .RST(RST), .EN(EN), .LOAD(LOAD), .d_ones(d_ones), .d_tens(d_tens),
    .ones(ones1), .tens(tens1), .tc(tc1), .borrow(borrow1), .done(done1));
  bcd_down_counter #(.WRAP_MODE(2)) u2 (
    .clk(clk), .RST(RST), .EN(EN), .LOAD(LOAD), .d_ones(d_ones), .d_tens(d_tens),
    .ones(ones2), .tens(tens2), .tc(tc2), .borrow(borrow2), .done(done2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    LOAD = 1'b1; EN = 1'b0; d_tens = t; d_ones = o;
    tick();
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    do_load(4'd5, 4'd7);
    EN = 1'b1;
    tick(); tick();
    RST = 1'b1; LOAD = 1'b1; EN = 1'b1; d_tens = 4'd5; d_ones = 4'd5;
    tick();
    n_cmp++;
    if ({tens0, ones0, done0, tc0} !== {8'h00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_m0: got %h%h done=%b tc=%b, want 00 done=0 tc=1", tens0, ones0, done0, tc0);
    end
    n_cmp++;
    if ({tens1, ones1, done1, tc1} !== {8'h00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_m1: got %h%h done=%b tc=%b, want 00 done=0 tc=1", tens1, ones1, done1, tc1);
    end
    n_cmp++;
    if ({tens2, ones2, done2, tc2} !== {8'h00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_m2: got %h%h done=%b tc=%b, want 00 done=0 tc=1", tens2, ones2, done2, tc2);
    end
    RST = 1'b0; LOAD = 1'b0; EN = 1'b0;
  endtask

  task automatic test_digit_borrow();
    logic [7:0] exp_seq [5] = '{8'h41, 8'h40, 8'h39, 8'h38, 8'h37};
    do_load(4'd4, 4'd2);
    n_cmp++;
    if ({tens0, ones0} !== 8'h42) begin
      n_bad++;
      $display("FAIL borrow_load: got %h%h, want 42", tens0, ones0);
    end
    EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({tens0, ones0, done0, borrow0} !== {exp_seq[i], 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL borrow_step%0d: got %h%h done=%b borrow=%b, want %h done=0 borrow=0",
                 i, tens0, ones0, done0, borrow0, exp_seq[i]);
      end
    end
    EN = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq [3] = '{8'h00, 8'h99, 8'h98};
    logic       exp_done [3] = '{1'b0, 1'b1, 1'b0};
    logic       exp_brw [3] = '{1'b1, 1'b0, 1'b0};
    do_load(4'd0, 4'd1);
    EN = 1'b1;
    n_cmp++;
    if (borrow0 !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_borrow_01: got %b, want 0", borrow0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({tens0, ones0, done0, borrow0} !== {exp_seq[i], exp_done[i], exp_brw[i]}) begin
        n_bad++;
        $display("FAIL wrap_step%0d: got %h%h done=%b borrow=%b, want %h done=%b borrow=%b",
                 i, tens0, ones0, done0, borrow0, exp_seq[i], exp_done[i], exp_brw[i]);
      end
    end
    EN = 1'b0;
    n_cmp++;
    if (borrow0 !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_borrow_noen: got %b, want 0", borrow0);
    end
  endtask

  task automatic test_reload();
    logic [7:0] exp_seq [5] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
    logic       exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_load(4'd0, 4'd3);
    EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({tens1, ones1, done1} !== {exp_seq[i], exp_done[i]}) begin
        n_bad++;
        $display("FAIL reload_step%0d: got %h%h done=%b, want %h done=%b",
                 i, tens1, ones1, done1, exp_seq[i], exp_done[i]);
      end
    end
    LOAD = 1'b1; d_tens = 4'd0; d_ones = 4'd0;
    tick();
    LOAD = 1'b0;
    n_cmp++;
    if ({tens1, ones1, done1} !== {8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reload_load00: got %h%h done=%b, want 00 done=0", tens1, ones1, done1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({tens1, ones1, done1} !== {8'h00, 1'b1}) begin
        n_bad++;
        $display("FAIL reload_zero%0d: got %h%h done=%b, want 00 done=1", i, tens1, ones1, done1);
      end
    end
    EN = 1'b0;
    tick();
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reload_hold_done: got %b, want 0", done1);
    end
  endtask

  task automatic test_stop();
    logic [7:0] exp_seq [5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       exp_done [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_load(4'd0, 4'd2);
    EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({tens2, ones2, done2, borrow2} !== {exp_seq[i], exp_done[i], 1'b0}) begin
        n_bad++;
        $display("FAIL stop_step%0d: got %h%h done=%b borrow=%b, want %h done=%b borrow=0",
                 i, tens2, ones2, done2, borrow2, exp_seq[i], exp_done[i]);
      end
    end
    n_cmp++;
    if (tc2 !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_tc: got %b, want 1", tc2);
    end
    EN = 1'b0;
  endtask

  task automatic test_load_edges();
    LOAD = 1'b1; EN = 1'b1; d_tens = 4'hC; d_ones = 4'hA;
    n_cmp++;
    if (borrow0 !== 1'b0) begin
      n_bad++;
      $display("FAIL load_borrow_gate: got %b, want 0", borrow0);
    end
    tick();
    LOAD = 1'b0;
    n_cmp++;
    if ({tens0, ones0, done0} !== {8'h99, 1'b0}) begin
      n_bad++;
      $display("FAIL load_sat: got %h%h done=%b, want 99 done=0", tens0, ones0, done0);
    end
    tick();
    n_cmp++;
    if ({tens0, ones0} !== 8'h98) begin
      n_bad++;
      $display("FAIL load_then_dec: got %h%h, want 98", tens0, ones0);
    end
    EN = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({tens0, ones0, done0} !== {8'h98, 1'b0}) begin
      n_bad++;
      $display("FAIL hold: got %h%h done=%b, want 98 done=0", tens0, ones0, done0);
    end
    RST = 1'b1; LOAD = 1'b1; d_tens = 4'd7; d_ones = 4'd7;
    tick();
    RST = 1'b0; LOAD = 1'b0;
    n_cmp++;
    if ({tens0, ones0} !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_over_load: got %h%h, want 00", tens0, ones0);
    end
  endtask

  task automatic test_reload_reset_rld();
    // After reset the reload register is 00, so mode 1 underflow stays at 00.
    EN = 1'b1;
    tick();
    n_cmp++;
    if ({tens1, ones1, done1} !== {8'h00, 1'b1}) begin
      n_bad++;
      $display("FAIL reload_after_rst: got %h%h done=%b, want 00 done=1", tens1, ones1, done1);
    end
    EN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; d_ones = 4'd0; d_tens = 4'd0;
    tick(); tick();
    RST = 1'b0;
    test_reset();
    test_digit_borrow();
    test_wrap();
    test_reload();
    test_stop();
    test_load_edges();
    test_reload_reset_rld();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
